rr_cnt_sched: RTL and testbench
===============================

RR_CNT_SCHED -- requirements
Module: rr_cnt_sched

Interface
REQ-001 Parameter N, default 4, number of requesters (2..8).
REQ-002 Parameter W, default 8, counter width.
REQ-003 clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 en  input  1  scheduler enable.
REQ-006 clr  input  1  synchronous counter clear, one-cycle pulse or level.
REQ-007 limit  input  W  terminal count; may change at any cycle.
REQ-008 req  input  N  per-requester request level, held by requester until its gnt bit is seen.
REQ-009 gnt  output  N  one-hot registered grant, one cycle wide per granted request.
REQ-010 inc  output  1  equals |gnt; increment strobe for a downstream cross-clock counter.
REQ-011 cnt  output  W  registered binary count of grants since last clear.
REQ-012 cnt_gray  output  W  registered Gray code of cnt, cnt ^ (cnt >> 1), updated on the same edge as cnt.
REQ-013 full  output  1  registered, high while state is FULL.

Function
REQ-014 The block SHALL implement states IDLE, RUN, FULL, held in a registered state variable.
REQ-015 IDLE->RUN when en=1 and cnt<limit; IDLE->FULL when en=1 and cnt>=limit.
REQ-016 RUN->FULL on the edge where cnt becomes equal to limit, or on any edge where limit<=cnt; FULL->RUN when limit rises above cnt.
REQ-017 RUN or FULL ->IDLE on any edge with en=0; cnt, cnt_gray and pointer SHALL be held in IDLE.
REQ-018 Arbitration SHALL occur only in RUN with en=1 and clr=0: the first requester with req=1 scanning from index ptr upward, modulo N, is selected.
REQ-019 The selected requester's gnt bit SHALL be high for exactly the cycle after the arbitration edge; at that same edge cnt and cnt_gray SHALL advance by one; latency req-to-gnt is 1 cycle minimum.
REQ-020 A requester whose gnt bit is high SHALL NOT be considered for arbitration in that cycle; at most one grant per two cycles per requester.
REQ-021 After granting index i, ptr SHALL become (i+1) mod N; ptr unchanged when no grant.
REQ-022 No grant SHALL be issued that would make cnt exceed limit; cnt never wraps.
REQ-023 limit=0 with en=1 SHALL give FULL with no grants.
REQ-024 clr=1 SHALL take priority over arbitration: cnt and cnt_gray <= 0, gnt <= 0, ptr unchanged, next state RUN if en=1 and limit>0, FULL if en=1 and limit=0, else IDLE.
REQ-025 en and clr simultaneous with a pending req: clr wins, no grant that cycle.
REQ-026 req bits of requesters not yet granted SHALL be held; deasserted req before grant is dropped without side effects.

Reset
REQ-027 rst=1 SHALL asynchronously set state IDLE, gnt=0, cnt=0, cnt_gray=0, full=0, ptr=0.
REQ-028 Reset asserted mid-grant SHALL clear gnt immediately; first grant after release needs one full arbitration edge.
REQ-029 inc SHALL be 0 throughout reset.

Verification
REQ-030 rst release, en=1, limit=10, req=4'b1111 held -> gnt order 0001,0010,0100,1000,0001,... one per cycle, cnt 1..10, full=1 after cnt=10, no 11th grant.
REQ-031 limit=3, only req[2] held -> gnt[2] high every other cycle, cnt 1,2,3, cnt_gray 1,3,2, then FULL.
REQ-032 cnt=5 in FULL (limit=5), raise limit to 8 -> state RUN next edge, three more grants, cnt=8, full=1.
REQ-033 clr pulsed at cnt=7 with req pending -> no grant that cycle, cnt=0, cnt_gray=0, ptr unchanged; grants resume next edge.
REQ-034 en=0 while req=1111 at cnt=4 -> state IDLE, gnt=0, cnt held 4; en=1 -> grants resume from saved ptr.
REQ-035 rst asserted asynchronously while gnt=0010 -> gnt, cnt, full forced to 0 before next clk edge.

Source files
------------

// File: rtl/rr_cnt_sched.sv
// Round-robin grant scheduler with a saturating grant counter and a Gray-coded copy.
// The controller moves between IDLE, RUN and FULL; grants are issued only in RUN and only while cnt < limit.
module rr_cnt_sched #(
  parameter int N = 4,
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] limit,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt,
  output logic         inc,
  output logic [W-1:0] cnt,
  output logic [W-1:0] cnt_gray,
  output logic         full
);

  localparam int unsigned NU = N;
  localparam int PW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FULL = 2'd2;

  logic [1:0]    state, state_nxt;
  logic [PW-1:0] ptr, ptr_nxt, pick_ptr;
  logic [N-1:0]  cand, pick, gnt_nxt;
  logic          pick_any;
  logic [W-1:0]  cnt_nxt;

  // A requester still showing its grant is masked so it cannot win twice in a row.
  always_comb begin
    cand     = req & ~gnt;
    pick     = '0;
    pick_any = 1'b0;
    pick_ptr = ptr;
    for (int unsigned k = 0; k < NU; k++) begin
      for (int unsigned j = 0; j < NU; j++) begin
        if (!pick_any && cand[j] && (j == ((32'(ptr) + k) % NU))) begin
          pick_any = 1'b1;
          pick[j]  = 1'b1;
          pick_ptr = PW'((j + 1) % NU);
        end
      end
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    gnt_nxt   = '0;
    cnt_nxt   = cnt;
    if (clr) begin
      cnt_nxt = '0;
      if (!en)
        state_nxt = IDLE;
      else
        state_nxt = (limit == '0) ? FULL : RUN;
    end else if (!en) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: state_nxt = (cnt < limit) ? RUN : FULL;
        RUN: begin
          if (cnt >= limit) begin
            state_nxt = FULL;
          end else if (pick_any) begin
            gnt_nxt = pick;
            cnt_nxt = cnt + 1'b1;
            ptr_nxt = pick_ptr;
            if (cnt_nxt == limit)
              state_nxt = FULL;
          end
        end
        FULL: if (limit > cnt) state_nxt = RUN;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= '0;
      gnt      <= '0;
      cnt      <= '0;
      cnt_gray <= '0;
      full     <= 1'b0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      gnt      <= gnt_nxt;
      cnt      <= cnt_nxt;
      cnt_gray <= cnt_nxt ^ (cnt_nxt >> 1);
      full     <= (state_nxt == FULL);
    end
  end

  assign inc = |gnt;

endmodule

// File: tb/tb_rr_cnt_sched.sv
// Directed, table-driven bench for rr_cnt_sched (N=4, W=8) with hand-computed expectations,
// plus a hand-written sequence for asynchronous reset in the middle of a grant.
module tb_rr_cnt_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       clr;
  logic [7:0] limit;
  logic [3:0] req;
  logic [3:0] gnt;
  logic       inc;
  logic [7:0] cnt;
  logic [7:0] cnt_gray;
  logic       full;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic       en;
    logic       clr;
    logic [7:0] lim;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [7:0] cnt;
    logic       full;
  } vec_t;

  vec_t tbl[$];

  rr_cnt_sched #(.N(4), .W(8)) dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .limit(limit), .req(req),
    .gnt(gnt), .inc(inc), .cnt(cnt), .cnt_gray(cnt_gray), .full(full)
  );

  always #5 clk = ~clk;

  task automatic add(input logic e, input logic c, input logic [7:0] l, input logic [3:0] r,
                     input logic [3:0] g, input logic [7:0] n, input logic f);
    vec_t v;
    v.en = e; v.clr = c; v.lim = l; v.req = r; v.gnt = g; v.cnt = n; v.full = f;
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input logic [3:0] g, input logic [7:0] n, input logic f);
    logic [7:0] gray;
    logic       inc_e;
    gray  = n ^ (n >> 1);
    inc_e = |g;
    vectors++;
    if (gnt !== g || cnt !== n || cnt_gray !== gray || full !== f || inc !== inc_e) begin
      miscompares++;
      $display("FAIL %s: got gnt=%b cnt=%0d gray=%0d full=%b inc=%b, want gnt=%b cnt=%0d gray=%0d full=%b inc=%b",
               name, gnt, cnt, cnt_gray, full, inc, g, n, gray, f, inc_e);
    end
  endtask

  initial begin
    // limit 10, all requesting: rotating grants, saturate at 10
    add(1,0,10,4'hF, 4'b0000, 0,0);
    add(1,0,10,4'hF, 4'b0001, 1,0);
    add(1,0,10,4'hF, 4'b0010, 2,0);
    add(1,0,10,4'hF, 4'b0100, 3,0);
    add(1,0,10,4'hF, 4'b1000, 4,0);
    add(1,0,10,4'hF, 4'b0001, 5,0);
    add(1,0,10,4'hF, 4'b0010, 6,0);
    add(1,0,10,4'hF, 4'b0100, 7,0);
    add(1,0,10,4'hF, 4'b1000, 8,0);
    add(1,0,10,4'hF, 4'b0001, 9,0);
    add(1,0,10,4'hF, 4'b0010,10,1);
    add(1,0,10,4'hF, 4'b0000,10,1);
    add(1,0,10,4'hF, 4'b0000,10,1);
    // raise limit while FULL
    add(1,0,12,4'hF, 4'b0000,10,0);
    add(1,0,12,4'hF, 4'b0100,11,0);
    add(1,0,12,4'hF, 4'b1000,12,1);
    add(1,0,12,4'hF, 4'b0000,12,1);
    // clear, then clear again with ptr=2 to show the pointer is kept
    add(1,1,12,4'hF, 4'b0000, 0,0);
    add(1,0,12,4'hF, 4'b0001, 1,0);
    add(1,0,12,4'hF, 4'b0010, 2,0);
    add(1,1,12,4'hF, 4'b0000, 0,0);
    add(1,0,12,4'hF, 4'b0100, 1,0);
    add(1,0,12,4'hF, 4'b1000, 2,0);
    add(1,0,12,4'hF, 4'b0001, 3,0);
    add(1,0,12,4'hF, 4'b0010, 4,0);
    // drop enable at cnt=4, resume from saved pointer
    add(0,0,12,4'hF, 4'b0000, 4,0);
    add(0,0,12,4'hF, 4'b0000, 4,0);
    add(1,0,12,4'hF, 4'b0000, 4,0);
    add(1,0,12,4'hF, 4'b0100, 5,0);
    // limit 0 via clear: FULL, no grants
    add(1,1, 0,4'hF, 4'b0000, 0,1);
    add(1,0, 0,4'hF, 4'b0000, 0,1);
    // limit 3, only req[2]: every other cycle
    add(1,0, 3,4'h4, 4'b0000, 0,0);
    add(1,0, 3,4'h4, 4'b0100, 1,0);
    add(1,0, 3,4'h4, 4'b0000, 1,0);
    add(1,0, 3,4'h4, 4'b0100, 2,0);
    add(1,0, 3,4'h4, 4'b0000, 2,0);
    add(1,0, 3,4'h4, 4'b0100, 3,1);
    add(1,0, 3,4'h4, 4'b0000, 3,1);
    // limit dropped below cnt while RUN; idle requests
    add(1,0, 6,4'hF, 4'b0000, 3,0);
    add(1,0, 2,4'hF, 4'b0000, 3,1);
    add(1,0, 6,4'h0, 4'b0000, 3,0);
    add(1,0, 6,4'h0, 4'b0000, 3,0);
    add(1,0, 6,4'h1, 4'b0001, 4,0);

    rst = 1'b1; en = 1'b0; clr = 1'b0; limit = '0; req = '0;
    @(posedge clk); #1;
    check("reset", 4'b0000, 0, 0);
    @(negedge clk); rst = 1'b0;

    foreach (tbl[i]) begin
      @(negedge clk);
      en = tbl[i].en; clr = tbl[i].clr; limit = tbl[i].lim; req = tbl[i].req;
      @(posedge clk); #1;
      check($sformatf("vec%0d", i), tbl[i].gnt, tbl[i].cnt, tbl[i].full);
    end

    // asynchronous reset while gnt=0010
    @(negedge clk); en = 1'b1; clr = 1'b0; limit = 8'd6; req = 4'b0010;
    @(posedge clk); #1;
    check("pre_rst_grant", 4'b0010, 5, 0);
    #2 rst = 1'b1;
    #1 check("async_rst", 4'b0000, 0, 0);
    @(posedge clk); #1;
    check("held_rst", 4'b0000, 0, 0);
    @(negedge clk); rst = 1'b0; limit = 8'd10; req = 4'hF;
    @(posedge clk); #1;
    check("post_rst_arm", 4'b0000, 0, 0);
    @(posedge clk); #1;
    check("post_rst_grant", 4'b0001, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
